// File: rtl/dplca_pkg.sv
// rtl/dplca_pkg.sv - shared FSM states and claim/enable constants for the DPLCA TXOP ager
package dplca_pkg;

    typedef enum logic [2:0] {
        DISABLED       = 3'd0,
        WAIT_TXOP_END  = 3'd1,
        TXOP_END       = 3'd2,
        UPDATE_CLAIMED = 3'd3,
        NOTIFY         = 3'd4
    } dplca_state_e;

    localparam logic CLAIMED   = 1'b1;
    localparam logic UNCLAIMED = 1'b0;
    localparam logic ON        = 1'b1;
    localparam logic OFF       = 1'b0;
    localparam logic TRUE      = 1'b1;
    localparam logic FALSE     = 1'b0;

endpackage

// File: rtl/dplca_free_search.sv
// rtl/dplca_free_search.sv - lowest-zero priority encoder over the TXOP claim table
module dplca_free_search #(
    parameter int NUM_TXOP = 256,
    localparam int ID_W = $clog2(NUM_TXOP)
) (
    input  logic [NUM_TXOP-1:0] claim_table,
    output logic [ID_W-1:0]     free_id,
    output logic                free_valid
);

    // Scan from the top so the last hit is the lowest free index.
    always_comb begin
        free_id    = '0;
        free_valid = 1'b0;
        for (int i = NUM_TXOP - 1; i >= 0; i--) begin
            if (!claim_table[i]) begin
                free_id    = ID_W'(i);
                free_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dplca_txop_ager.sv
// rtl/dplca_txop_ager.sv - DPLCA TXOP claim-table ager; DPLCA_FREE_SEARCH_EN adds free_id/free_valid
module dplca_txop_ager
    import dplca_pkg::*;
#(
    parameter int NUM_TXOP = 256,
    parameter int AGE_W    = 16,
    localparam int ID_W    = $clog2(NUM_TXOP)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dplca_aging,
    input  logic                dplca_txop_end,
    input  logic                dplca_txop_claim,
    input  logic [ID_W-1:0]     dplca_txop_id,
    input  logic [AGE_W-1:0]    aging_cycles,
    input  logic [ID_W-1:0]     rd_id,
    output logic                rd_claimed,
    output logic [NUM_TXOP-1:0] txop_claim_table,
    output logic [NUM_TXOP-1:0] txop_claim_table_new,
    output logic [ID_W:0]       claimed_count,
    output logic [AGE_W-1:0]    aging_cnt,
    output logic                dplca_new_age,
    output logic                dplca_txop_table_upd,
    output logic [2:0]          state
`ifdef DPLCA_FREE_SEARCH_EN
    ,
    output logic [ID_W-1:0]     free_id,
    output logic                free_valid
`endif
);

    localparam logic [ID_W:0] TXOP_LIMIT = (ID_W + 1)'(NUM_TXOP);

    dplca_state_e state_q;
    dplca_state_e state_d;
    logic [ID_W-1:0] id_q;
    logic            claim_q;
    logic            id_q_in_range;
    logic            entering_wait;

    assign state          = state_q;
    assign id_q_in_range  = ({1'b0, id_q} < TXOP_LIMIT);
    assign entering_wait  = (state_d == WAIT_TXOP_END) && (state_q != WAIT_TXOP_END);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= DISABLED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DISABLED:       state_d = WAIT_TXOP_END;
            WAIT_TXOP_END:  if (dplca_txop_end) state_d = TXOP_END;
            TXOP_END:       state_d = (claim_q == CLAIMED) ? UPDATE_CLAIMED : NOTIFY;
            UPDATE_CLAIMED: state_d = NOTIFY;
            NOTIFY:         if (!dplca_txop_end) state_d = WAIT_TXOP_END;
            default:        state_d = DISABLED;
        endcase
        if (dplca_aging == OFF) begin
            state_d = DISABLED;
        end
    end

    // Aging is applied on the sampling edge, ahead of the claim write two cycles later,
    // so an ID-0 claim in a rolling cycle lands in the freshly promoted tables.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txop_claim_table     <= '0;
            txop_claim_table_new <= '0;
            aging_cnt            <= '0;
            dplca_new_age        <= FALSE;
            dplca_txop_table_upd <= FALSE;
            id_q                 <= '0;
            claim_q              <= UNCLAIMED;
        end else if (dplca_aging == OFF) begin
            txop_claim_table     <= '0;
            txop_claim_table_new <= '0;
            aging_cnt            <= '0;
            dplca_new_age        <= FALSE;
            dplca_txop_table_upd <= FALSE;
        end else begin
            if (entering_wait) begin
                dplca_new_age        <= FALSE;
                dplca_txop_table_upd <= FALSE;
            end
            case (state_q)
                WAIT_TXOP_END: begin
                    if (dplca_txop_end) begin
                        id_q    <= dplca_txop_id;
                        claim_q <= dplca_txop_claim;
                        if (dplca_txop_id == '0) begin
                            if (aging_cnt >= aging_cycles) begin
                                txop_claim_table     <= txop_claim_table_new;
                                txop_claim_table_new <= '0;
                                aging_cnt            <= '0;
                                dplca_new_age        <= TRUE;
                            end else begin
                                aging_cnt <= aging_cnt + 1'b1;
                            end
                        end
                    end
                end
                TXOP_END: begin
                    if (claim_q == UNCLAIMED) begin
                        dplca_txop_table_upd <= TRUE;
                    end
                end
                UPDATE_CLAIMED: begin
                    if (id_q_in_range) begin
                        txop_claim_table[id_q]     <= CLAIMED;
                        txop_claim_table_new[id_q] <= CLAIMED;
                    end
                    dplca_txop_table_upd <= TRUE;
                end
                default: ;
            endcase
        end
    end

    assign rd_claimed = ({1'b0, rd_id} < TXOP_LIMIT) ? txop_claim_table[rd_id] : 1'b0;

    always_comb begin
        claimed_count = '0;
        for (int i = 0; i < NUM_TXOP; i++) begin
            claimed_count = claimed_count + (ID_W + 1)'(txop_claim_table[i]);
        end
    end

`ifdef DPLCA_FREE_SEARCH_EN
    logic [ID_W-1:0] search_id;
    logic            search_valid;

    dplca_free_search #(
        .NUM_TXOP (NUM_TXOP)
    ) u_free_search (
        .claim_table (txop_claim_table),
        .free_id     (search_id),
        .free_valid  (search_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            free_id    <= '0;
            free_valid <= TRUE;
        end else begin
            free_id    <= search_id;
            free_valid <= search_valid;
        end
    end
`endif

endmodule

// File: tb/tb_dplca_txop_ager.sv
// tb/tb_dplca_txop_ager.sv - scoreboard bench for dplca_txop_ager (8- and 6-entry instances)
module tb_dplca_txop_ager;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dplca_aging;
    logic       dplca_txop_end;
    logic       dplca_txop_claim;
    logic [2:0] dplca_txop_id;
    logic [3:0] aging_cycles;
    logic [2:0] rd_id;

    logic       rd_claimed8, new_age8, upd8;
    logic [7:0] tbl8, tbl_new8;
    logic [3:0] count8, aging_cnt8;
    logic [2:0] state8;

    logic       rd_claimed6, new_age6, upd6;
    logic [5:0] tbl6, tbl_new6;
    logic [3:0] count6, aging_cnt6;
    logic [2:0] state6;

`ifdef DPLCA_FREE_SEARCH_EN
    logic [2:0] free_id8, free_id6;
    logic       free_valid8, free_valid6;
`endif

    always #5 clk = ~clk;

    dplca_txop_ager #(.NUM_TXOP(8), .AGE_W(4)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .dplca_aging          (dplca_aging),
        .dplca_txop_end       (dplca_txop_end),
        .dplca_txop_claim     (dplca_txop_claim),
        .dplca_txop_id        (dplca_txop_id),
        .aging_cycles         (aging_cycles),
        .rd_id                (rd_id),
        .rd_claimed           (rd_claimed8),
        .txop_claim_table     (tbl8),
        .txop_claim_table_new (tbl_new8),
        .claimed_count        (count8),
        .aging_cnt            (aging_cnt8),
        .dplca_new_age        (new_age8),
        .dplca_txop_table_upd (upd8),
        .state                (state8)
`ifdef DPLCA_FREE_SEARCH_EN
        ,
        .free_id              (free_id8),
        .free_valid           (free_valid8)
`endif
    );

    dplca_txop_ager #(.NUM_TXOP(6), .AGE_W(4)) dut6 (
        .clk                  (clk),
        .rst_n                (rst_n),
        .dplca_aging          (dplca_aging),
        .dplca_txop_end       (dplca_txop_end),
        .dplca_txop_claim     (dplca_txop_claim),
        .dplca_txop_id        (dplca_txop_id),
        .aging_cycles         (aging_cycles),
        .rd_id                (rd_id),
        .rd_claimed           (rd_claimed6),
        .txop_claim_table     (tbl6),
        .txop_claim_table_new (tbl_new6),
        .claimed_count        (count6),
        .aging_cnt            (aging_cnt6),
        .dplca_new_age        (new_age6),
        .dplca_txop_table_upd (upd6),
        .state                (state6)
`ifdef DPLCA_FREE_SEARCH_EN
        ,
        .free_id              (free_id6),
        .free_valid           (free_valid6)
`endif
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic [7:0] m8, n8;
    logic [5:0] m6, n6;
    int         mcnt;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=%0h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic check_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        push(tag, exp);
        pop_check(obs);
    endtask

    task automatic model_clear();
        m8 = '0; n8 = '0; m6 = '0; n6 = '0; mcnt = 0;
    endtask

    // One TXOP from WAIT back to WAIT, holding txop_end for 'hold' extra NOTIFY cycles.
    task automatic run_txop(input logic [2:0] id, input logic claim, input int hold);
        logic rolled;
        rolled = 1'b0;
        dplca_txop_end   = 1'b1;
        dplca_txop_id    = id;
        dplca_txop_claim = claim;
        if (id == 3'd0) begin
            if (mcnt >= int'(aging_cycles)) begin
                m8 = n8; n8 = '0; m6 = n6; n6 = '0; mcnt = 0; rolled = 1'b1;
            end else begin
                mcnt++;
            end
        end
        push("new_age_t", 32'(rolled));
        push("aging_cnt_t", 32'(mcnt));
        push("state_t", 32'd2);
        step();
        pop_check(32'(new_age8));
        pop_check(32'(aging_cnt8));
        pop_check(32'(state8));
        if (claim) begin
            if (id < 3'd6) begin m6[id] = 1'b1; n6[id] = 1'b1; end
            m8[id] = 1'b1;
            n8[id] = 1'b1;
            push("state_upd", 32'd3);
            step();
            pop_check(32'(state8));
        end
        push("state_notify", 32'd4);
        push("upd", 32'd1);
        push("tbl", 32'(m8));
        push("tbl_new", 32'(n8));
        push("count", 32'($countones(m8)));
        push("tbl6", 32'(m6));
        push("tbl_new6", 32'(n6));
        push("count6", 32'($countones(m6)));
        push("upd6", 32'd1);
        step();
        pop_check(32'(state8));
        pop_check(32'(upd8));
        pop_check(32'(tbl8));
        pop_check(32'(tbl_new8));
        pop_check(32'(count8));
        pop_check(32'(tbl6));
        pop_check(32'(tbl_new6));
        pop_check(32'(count6));
        pop_check(32'(upd6));
        for (int h = 0; h < hold; h++) begin
            push("hold_state", 32'd4);
            push("hold_upd", 32'd1);
            push("hold_new_age", 32'(rolled));
            step();
            pop_check(32'(state8));
            pop_check(32'(upd8));
            pop_check(32'(new_age8));
        end
        dplca_txop_end = 1'b0;
        push("wait_state", 32'd1);
        push("wait_upd", 32'd0);
        push("wait_new_age", 32'd0);
        step();
        pop_check(32'(state8));
        pop_check(32'(upd8));
        pop_check(32'(new_age8));
    endtask

    task automatic disable_and_clear();
        dplca_aging = 1'b0;
        step();
        model_clear();
        check_now("clr_state", 32'(state8), 32'd0);
        check_now("clr_tbl", 32'(tbl8), 32'd0);
        dplca_aging = 1'b1;
        step();
        check_now("clr_wait", 32'(state8), 32'd1);
    endtask

`ifdef DPLCA_FREE_SEARCH_EN
    task automatic check_free();
        int   lowest;
        logic found;
        lowest = 0;
        found  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && !m8[i]) begin
                lowest = i;
                found  = 1'b1;
            end
        end
        check_now("free_id", 32'(free_id8), 32'(lowest));
        check_now("free_valid", 32'(free_valid8), 32'(found));
    endtask
`endif

    initial begin
        rst_n            = 1'b0;
        dplca_aging      = 1'b0;
        dplca_txop_end   = 1'b0;
        dplca_txop_claim = 1'b0;
        dplca_txop_id    = 3'd0;
        aging_cycles     = 4'd2;
        rd_id            = 3'd0;
        model_clear();

        step();
        step();
        check_now("rst_tbl", 32'(tbl8), 32'h00);
        check_now("rst_tbl_new", 32'(tbl_new8), 32'h00);
        check_now("rst_aging_cnt", 32'(aging_cnt8), 32'd0);
        check_now("rst_state", 32'(state8), 32'd0);
        check_now("rst_upd", 32'(upd8), 32'd0);
        check_now("rst_new_age", 32'(new_age8), 32'd0);
`ifdef DPLCA_FREE_SEARCH_EN
        check_now("rst_free_id", 32'(free_id8), 32'd0);
        check_now("rst_free_valid", 32'(free_valid8), 32'd1);
`endif

        rst_n       = 1'b1;
        dplca_aging = 1'b1;
        step();
        check_now("en_state", 32'(state8), 32'd1);

        // Claim ID 3, holding txop_end for two extra cycles
        rd_id = 3'd3;
        run_txop(3'd3, 1'b1, 2);
        check_now("rd_claimed3", 32'(rd_claimed8), 32'd1);
        check_now("tbl_is_08", 32'(tbl8), 32'h08);

        // Aging: ID 5 pre-claimed, then three unclaimed ID-0 TXOPs
        disable_and_clear();
        run_txop(3'd5, 1'b1, 0);
        run_txop(3'd0, 1'b0, 0);
        check_now("age_cnt1", 32'(aging_cnt8), 32'd1);
        run_txop(3'd0, 1'b0, 0);
        check_now("age_cnt2", 32'(aging_cnt8), 32'd2);
        run_txop(3'd0, 1'b0, 1);
        check_now("age_tbl_20", 32'(tbl8), 32'h20);
        check_now("age_new_00", 32'(tbl_new8), 32'h00);

        // ID-0 claim in a rolling cycle lands after the promotion
        run_txop(3'd4, 1'b1, 0);
        run_txop(3'd0, 1'b0, 0);
        run_txop(3'd0, 1'b0, 0);
        run_txop(3'd0, 1'b1, 0);
        check_now("order_tbl", 32'(tbl8), 32'h11);
        check_now("order_new", 32'(tbl_new8), 32'h01);

        // Lowered aging_cycles rolls on the next ID-0 TXOP
        aging_cycles = 4'd0;
        run_txop(3'd0, 1'b0, 0);
        aging_cycles = 4'd2;

        // Disable during UPDATE_CLAIMED for ID 2
        disable_and_clear();
        dplca_txop_end   = 1'b1;
        dplca_txop_id    = 3'd2;
        dplca_txop_claim = 1'b1;
        step();
        step();
        check_now("dis_in_update", 32'(state8), 32'd3);
        dplca_aging = 1'b0;
        step();
        model_clear();
        check_now("dis_state", 32'(state8), 32'd0);
        check_now("dis_tbl", 32'(tbl8), 32'h00);
        check_now("dis_tbl_new", 32'(tbl_new8), 32'h00);
        check_now("dis_aging_cnt", 32'(aging_cnt8), 32'd0);
        dplca_txop_end = 1'b0;
        dplca_aging    = 1'b1;
        step();
        check_now("dis_state_wait", 32'(state8), 32'd1);
        step();
        check_now("dis_bit2_never", 32'(tbl8), 32'h00);

        // Out-of-range ID on the 6-entry instance
        run_txop(3'd1, 1'b1, 0);
        run_txop(3'd7, 1'b1, 0);
        rd_id = 3'd7;
        #1;
        check_now("oor_rd6", 32'(rd_claimed6), 32'd0);
        check_now("oor_rd8", 32'(rd_claimed8), 32'd1);
        check_now("oor_count6", 32'(count6), 32'd1);
        check_now("oor_tbl6", 32'(tbl6), 32'h02);

`ifdef DPLCA_FREE_SEARCH_EN
        disable_and_clear();
        run_txop(3'd0, 1'b1, 0);
        run_txop(3'd1, 1'b1, 0);
        run_txop(3'd3, 1'b1, 0);
        check_free();
        run_txop(3'd2, 1'b1, 0);
        run_txop(3'd4, 1'b1, 0);
        run_txop(3'd5, 1'b1, 0);
        run_txop(3'd6, 1'b1, 0);
        check_free();
        run_txop(3'd7, 1'b1, 0);
        check_free();
        check_now("full_free_valid", 32'(free_valid8), 32'd0);
`endif

        check_now("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
